// File: rtl/mem_resp.sv
// Byte-wide memory responder: RAM below IO_BASE, and a memory-mapped output FIFO
// with status/overflow register in the I/O region above it.
module mem_resp #(
    parameter int          ADDR_W  = 17,
    parameter int          FIFO_AW = 4,
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rom_a,
    input  logic [7:0]  rom_wn,
    input  logic        rom_wr,
    output logic [7:0]  rom_rn,
    output logic [7:0]  io_dout,
    output logic        io_valid,
    input  logic        io_ready,
    output logic        io_ovf
);

    localparam int               RAM_DEPTH  = 1 << ADDR_W;
    localparam int               FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [31:0]      IO_DATA    = IO_BASE;
    localparam logic [31:0]      IO_STAT    = IO_BASE + 32'd4;
    localparam logic [FIFO_AW:0] PTR_ONE    = 1;

    logic [7:0]         ram      [RAM_DEPTH];
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [ADDR_W-1:0]  ram_idx;
    logic [7:0]         status;
    logic [7:0]         ram_q;
    logic [7:0]         reg_q;
    logic               sel_ram;
    logic               is_io;
    logic               push_req;
    logic               clr_req;
    logic               pop;
    logic               full;
    logic               empty;
    logic               push_ok;
    logic               overflow;

    assign is_io    = (rom_a >= IO_BASE);
    assign ram_idx  = rom_a[ADDR_W-1:0];
    assign push_req = rom_wr && (rom_a == IO_DATA);
    assign clr_req  = rom_wr && (rom_a == IO_STAT);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // Output handshake: a byte transfers on every rising edge where io_valid
    // and io_ready are both high; io_dout is held stable until that edge.
    assign io_valid = !empty;
    assign io_dout  = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign pop      = io_valid && io_ready;

    // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);
    assign overflow = push_req && full && !pop;

    assign status = {io_ovf, 2'b00, 5'(count)};

    // Storage arrays carry no reset so they can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (rom_wr && !is_io) begin
            ram[ram_idx] <= rom_wn;
        end
        ram_q <= ram[ram_idx];
        if (push_ok) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= rom_wn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            io_ovf  <= 1'b0;
            sel_ram <= 1'b0;
            reg_q   <= 8'h00;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (overflow) begin
                io_ovf <= 1'b1;
            end else if (clr_req) begin
                io_ovf <= 1'b0;
            end
            sel_ram <= !rom_wr && !is_io;
            reg_q   <= (!rom_wr && rom_a == IO_STAT) ? status : 8'h00;
        end
    end

    // sel_ram resets low, so the unreset RAM output never leaks through during reset.
    assign rom_rn = sel_ram ? ram_q : reg_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed scenarios plus randomized traffic
// compared against a queue/array reference model.
module tb_mem_resp;

    localparam int          ADDR_W  = 17;
    localparam int          FIFO_AW = 4;
    localparam int          DEPTH   = 16;
    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rom_a = '0;
    logic [7:0]  rom_wn = '0;
    logic        rom_wr = 1'b0;
    logic [7:0]  rom_rn;
    logic [7:0]  io_dout;
    logic        io_valid;
    logic        io_ready = 1'b0;
    logic        io_ovf;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic [7:0] ram_m[int];

    mem_resp #(.ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW), .IO_BASE(IO_BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .rom_a    (rom_a),
        .rom_wn   (rom_wn),
        .rom_wr   (rom_wr),
        .rom_rn   (rom_rn),
        .io_dout  (io_dout),
        .io_valid (io_valid),
        .io_ready (io_ready),
        .io_ovf   (io_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle, called at a falling edge; model is advanced and compared after the rising edge.
    task automatic step(input logic wr, input logic [31:0] a, input logic [7:0] wn, input logic rdy);
        logic [7:0] exp_rn;
        bit         rn_known;
        bit         do_pop;
        bit         do_push;
        bit         ovf_now;
        int         sz0;
        int         idx;
        rom_wr   = wr;
        rom_a    = a;
        rom_wn   = wn;
        io_ready = rdy;
        sz0      = exp_q.size();
        idx      = int'(a % (32'd1 << ADDR_W));
        rn_known = 1'b1;
        if (wr) exp_rn = 8'h00;
        else if (a >= IO_BASE) exp_rn = (a == IO_BASE + 32'd4) ? {exp_ovf, 2'b00, 5'(sz0)} : 8'h00;
        else if (ram_m.exists(idx)) exp_rn = ram_m[idx];
        else begin
            rn_known = 1'b0;
            exp_rn   = 8'h00;
        end
        do_pop  = (sz0 > 0) && rdy;
        do_push = wr && (a == IO_BASE);
        ovf_now = do_push && (sz0 == DEPTH) && !do_pop;
        @(posedge clk);
        #1;
        if (wr && a < IO_BASE) ram_m[idx] = wn;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push && !ovf_now) exp_q.push_back(wn);
        if (ovf_now) exp_ovf = 1'b1;
        else if (wr && a == IO_BASE + 32'd4) exp_ovf = 1'b0;
        if (rn_known) check("rom_rn", rom_rn, exp_rn);
        check("io_valid", io_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("io_dout", io_dout, exp_q[0]);
        check("io_ovf", io_ovf, exp_ovf);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        #12;
        check("reset_rom_rn", rom_rn, 8'h00);
        check("reset_valid", io_valid, 1'b0);
        check("reset_ovf", io_ovf, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Write then read back, including aliasing above ADDR_W.
        step(1'b1, 32'h0000_0123, 8'hA5, 1'b0);
        step(1'b0, 32'h0000_0123, 8'h00, 1'b0);
        check("rd_a5", rom_rn, 8'hA5);
        step(1'b1, 32'h0002_0010, 8'h3C, 1'b0);
        step(1'b0, 32'h0000_0010, 8'h00, 1'b0);
        check("alias_3c", rom_rn, 8'h3C);

        // Fill past full with host stalled.
        for (int i = 1; i <= 17; i++) step(1'b1, IO_BASE, 8'(i), 1'b0);
        step(1'b0, IO_BASE + 32'd4, 8'h00, 1'b0);
        check("stat_full_ovf", rom_rn, 8'h90);
        check("head_01", io_dout, 8'h01);
        step(1'b1, IO_BASE + 32'd4, 8'h00, 1'b0);
        step(1'b0, IO_BASE + 32'd4, 8'h00, 1'b0);
        check("stat_after_clr", rom_rn, 8'h10);

        // Push while full and popping: accepted, no overflow.
        step(1'b1, IO_BASE, 8'h77, 1'b1);
        step(1'b0, IO_BASE + 32'd4, 8'h00, 1'b0);
        check("stat_pp_full", rom_rn, 8'h10);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", io_dout, (i < 15) ? 32'(i + 2) : 32'h77);
            step(1'b0, 32'h0000_0123, 8'h00, 1'b1);
        end
        check("drained_valid", io_valid, 1'b0);

        // Push and pop request while empty: push only.
        step(1'b1, IO_BASE, 8'h5A, 1'b1);
        check("pp_empty_valid", io_valid, 1'b1);
        check("pp_empty_head", io_dout, 8'h5A);
        step(1'b0, 32'h0000_0000, 8'h00, 1'b1);

        // Other I/O addresses have no effect and read as zero.
        step(1'b1, IO_BASE + 32'd8, 8'hEE, 1'b0);
        step(1'b0, IO_BASE + 32'd8, 8'h00, 1'b0);

        // Randomized traffic across pointer wrap, with overflows and clears.
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 1) != 0 ? 32'h0002_0000 : 32'h0) | 32'($urandom_range(0, 31));
            case (op)
                0, 1, 2, 3: step(1'b1, IO_BASE, 8'($urandom), 1'($urandom_range(0, 1)));
                4:          step(1'b0, IO_BASE + 32'd4, 8'h00, 1'($urandom_range(0, 1)));
                5:          step(1'b1, IO_BASE + 32'd4, 8'h00, 1'($urandom_range(0, 1)));
                6, 7:       step(1'b1, a, 8'($urandom), 1'($urandom_range(0, 1)));
                default:    step(1'b0, a, 8'h00, 1'($urandom_range(0, 1)));
            endcase
        end
        for (int n = 0; n < DEPTH + 2; n++) step(1'b0, IO_BASE + 32'd4, 8'h00, 1'b1);

        // Asynchronous reset mid-cycle with bytes queued and a read result held.
        for (int i = 0; i < 3; i++) step(1'b1, IO_BASE, 8'(8'hC0 + i), 1'b0);
        step(1'b0, 32'h0000_0123, 8'h00, 1'b0);
        check("pre_rst_rn", rom_rn, 8'hA5);
        #2;
        rst = 1'b0;
        #1;
        check("rst_valid", io_valid, 1'b0);
        check("rst_rom_rn", rom_rn, 8'h00);
        check("rst_ovf", io_ovf, 1'b0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, IO_BASE + 32'd4, 8'h00, 1'b0);
        check("post_rst_stat", rom_rn, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
